// File: rtl/npc_predictor.sv
// Next-PC generator: direct-mapped BTB with 2-bit counters predicting from the fetch PC,
// plus EX-stage mispredict redirect/flush and table training.
module npc_predictor #(
   parameter int         ENTRIES  = 16,
   parameter int         IDX_W    = 4,
   parameter logic [1:0] CTR_INIT = 2'b10
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] pc_in,
   input  logic        stall,
   input  logic        ex_valid,
   input  logic        ex_is_branch,
   input  logic [31:0] ex_pc,
   input  logic        ex_taken,
   input  logic [31:0] ex_target,
   input  logic        ex_pred_taken,
   input  logic [31:0] ex_pred_target,
   output logic [31:0] nextpc,
   output logic        pcenable,
   output logic        pred_taken,
   output logic [31:0] pred_target,
   output logic        flush,
   output logic [15:0] mispredict_cnt
);

   localparam int TAG_W = 32 - IDX_W - 2;

   logic [ENTRIES-1:0] valid_q, valid_d;
   logic [TAG_W-1:0]   tag_q [ENTRIES];
   logic [TAG_W-1:0]   tag_d [ENTRIES];
   logic [31:0]        tgt_q [ENTRIES];
   logic [31:0]        tgt_d [ENTRIES];
   logic [1:0]         ctr_q [ENTRIES];
   logic [1:0]         ctr_d [ENTRIES];
   logic [15:0]        cnt_q, cnt_d;

   logic [IDX_W-1:0] fe_idx, ex_idx;
   logic [TAG_W-1:0] fe_tag, ex_tag;
   logic             fe_hit, ex_hit, mispredict;
   logic [31:0]      fe_pc4, ex_pc4, correct_pc;

   // Word-offset bits never take part in indexing or tagging.
   logic unused_bits;
   assign unused_bits = &{1'b0, pc_in[1:0], ex_pc[1:0]};

   always_comb begin
      fe_idx      = pc_in[IDX_W+1:2];
      fe_tag      = pc_in[31:IDX_W+2];
      fe_pc4      = pc_in + 32'd4;
      fe_hit      = valid_q[fe_idx] && (tag_q[fe_idx] == fe_tag);
      pred_taken  = fe_hit && ctr_q[fe_idx][1];
      pred_target = pred_taken ? tgt_q[fe_idx] : fe_pc4;

      ex_idx = ex_pc[IDX_W+1:2];
      ex_tag = ex_pc[31:IDX_W+2];
      ex_pc4 = ex_pc + 32'd4;
      ex_hit = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);

      mispredict = 1'b0;
      if (ex_valid) begin
         if (ex_is_branch)
            mispredict = (ex_taken != ex_pred_taken) ||
                         (ex_taken && (ex_target != ex_pred_target));
         else
            mispredict = ex_pred_taken;
      end
      correct_pc = (ex_is_branch && ex_taken) ? ex_target : ex_pc4;

      // A redirect must win over a stall or the wrong-path PC would be held.
      nextpc   = mispredict ? correct_pc : pred_target;
      flush    = mispredict;
      pcenable = mispredict || !stall;
      mispredict_cnt = cnt_q;
   end

   always_comb begin
      valid_d = valid_q;
      tag_d   = tag_q;
      tgt_d   = tgt_q;
      ctr_d   = ctr_q;
      cnt_d   = cnt_q;
      if (ex_valid) begin
         if (ex_is_branch) begin
            if (ex_hit) begin
               if (ex_taken) begin
                  if (ctr_q[ex_idx] != 2'b11) ctr_d[ex_idx] = ctr_q[ex_idx] + 2'd1;
                  tgt_d[ex_idx] = ex_target;
               end else if (ctr_q[ex_idx] != 2'b00) begin
                  ctr_d[ex_idx] = ctr_q[ex_idx] - 2'd1;
               end
            end else if (ex_taken) begin
               valid_d[ex_idx] = 1'b1;
               tag_d[ex_idx]   = ex_tag;
               tgt_d[ex_idx]   = ex_target;
               ctr_d[ex_idx]   = CTR_INIT;
            end
         end else if (ex_pred_taken) begin
            // Predicted a non-branch as taken: the entry aliases, drop it.
            valid_d[ex_idx] = 1'b0;
         end
      end
      if (mispredict && (cnt_q != 16'hFFFF)) cnt_d = cnt_q + 16'd1;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         valid_q <= '0;
         cnt_q   <= '0;
         for (int i = 0; i < ENTRIES; i++) begin
            tag_q[i] <= '0;
            tgt_q[i] <= '0;
            ctr_q[i] <= 2'b01;
         end
      end else begin
         valid_q <= valid_d;
         tag_q   <= tag_d;
         tgt_q   <= tgt_d;
         ctr_q   <= ctr_d;
         cnt_q   <= cnt_d;
      end
   end

endmodule

// File: tb/tb_npc_predictor.sv
// Scoreboard bench for npc_predictor: each stimulus row carries its hand-derived
// expected outputs, queued at drive time and compared before the next rising edge.
module tb_npc_predictor;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] pc_in, ex_pc, ex_target, ex_pred_target;
   logic        stall, ex_valid, ex_is_branch, ex_taken, ex_pred_taken;
   logic [31:0] nextpc, pred_target;
   logic        pcenable, pred_taken, flush;
   logic [15:0] mispredict_cnt;

   always #5 clk = ~clk;

   npc_predictor dut (
      .clk(clk), .rst(rst), .pc_in(pc_in), .stall(stall),
      .ex_valid(ex_valid), .ex_is_branch(ex_is_branch), .ex_pc(ex_pc),
      .ex_taken(ex_taken), .ex_target(ex_target), .ex_pred_taken(ex_pred_taken),
      .ex_pred_target(ex_pred_target), .nextpc(nextpc), .pcenable(pcenable),
      .pred_taken(pred_taken), .pred_target(pred_target), .flush(flush),
      .mispredict_cnt(mispredict_cnt)
   );

   typedef struct packed {
      logic [31:0] nextpc; logic pcen; logic flush; logic pt; logic [31:0] ptgt; logic [15:0] cnt;
   } obs_t;
   typedef struct packed {
      logic [31:0] pc; logic stall; logic v; logic br; logic [31:0] expc; logic tk;
      logic [31:0] tgt; logic ppt; logic [31:0] pptgt; obs_t e;
   } stim_t;

   obs_t exp_q[$];
   int   checks = 0;
   int   passes = 0;

   function automatic obs_t ob(input logic [31:0] npc, input logic pcen, input logic fl,
                               input logic pt, input logic [31:0] ptgt, input logic [15:0] cnt);
      obs_t o;
      o = {npc, pcen, fl, pt, ptgt, cnt};
      return o;
   endfunction

   function automatic stim_t exs(input logic [31:0] pc, input logic st, input logic v,
                                 input logic br, input logic [31:0] expc, input logic tk,
                                 input logic [31:0] tgt, input logic ppt,
                                 input logic [31:0] pptgt, input obs_t e);
      stim_t s;
      s = {pc, st, v, br, expc, tk, tgt, ppt, pptgt, e};
      return s;
   endfunction

   function automatic stim_t noex(input logic [31:0] pc, input logic st, input obs_t e);
      return exs(pc, st, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, e);
   endfunction

   function automatic obs_t sample();
      obs_t o;
      o = {nextpc, pcenable, flush, pred_taken, pred_target, mispredict_cnt};
      return o;
   endfunction

   task automatic drive(input stim_t s);
      pc_in = s.pc; stall = s.stall; ex_valid = s.v; ex_is_branch = s.br; ex_pc = s.expc;
      ex_taken = s.tk; ex_target = s.tgt; ex_pred_taken = s.ppt; ex_pred_target = s.pptgt;
      exp_q.push_back(s.e);
   endtask

   task automatic test_reset();
      obs_t e, o;
      rst = 1'b0;
      drive(noex(32'h100, 1'b0, ob(32'h104, 1, 0, 0, 32'h104, 16'd0)));
      #2;
      e = exp_q.pop_front(); o = sample(); checks++;
      if (o !== e) $display("FAIL reset got %h want %h", o, e); else passes++;
      @(negedge clk); rst = 1'b1;
   endtask

   task automatic test_alloc();
      stim_t t[$]; obs_t e, o;
      t.push_back(exs(32'h300, 0, 1, 1, 32'h100, 1, 32'h200, 0, 32'h0,
                      ob(32'h200, 1, 1, 0, 32'h304, 16'd0)));
      t.push_back(noex(32'h100, 0, ob(32'h200, 1, 0, 1, 32'h200, 16'd1)));
      foreach (t[i]) begin
         @(posedge clk); #1; drive(t[i]);
         @(negedge clk); e = exp_q.pop_front(); o = sample(); checks++;
         if (o !== e) $display("FAIL alloc[%0d] got %h want %h", i, o, e); else passes++;
      end
   endtask

   task automatic test_train_down();
      stim_t t[$]; obs_t e, o;
      t.push_back(exs(32'h100, 0, 1, 1, 32'h100, 0, 32'h0, 1, 32'h200,
                      ob(32'h104, 1, 1, 1, 32'h200, 16'd1)));
      t.push_back(exs(32'h100, 0, 1, 1, 32'h100, 0, 32'h0, 1, 32'h200,
                      ob(32'h104, 1, 1, 0, 32'h104, 16'd2)));
      t.push_back(noex(32'h100, 0, ob(32'h104, 1, 0, 0, 32'h104, 16'd3)));
      foreach (t[i]) begin
         @(posedge clk); #1; drive(t[i]);
         @(negedge clk); e = exp_q.pop_front(); o = sample(); checks++;
         if (o !== e) $display("FAIL train_down[%0d] got %h want %h", i, o, e); else passes++;
      end
   endtask

   task automatic test_stall();
      stim_t t[$]; obs_t e, o;
      t.push_back(noex(32'h100, 1, ob(32'h104, 0, 0, 0, 32'h104, 16'd3)));
      // Redirect during stall; training still happens (ctr 00->01).
      t.push_back(exs(32'h100, 1, 1, 1, 32'h100, 1, 32'h200, 0, 32'h0,
                      ob(32'h200, 1, 1, 0, 32'h104, 16'd3)));
      t.push_back(exs(32'h100, 0, 1, 1, 32'h100, 1, 32'h200, 0, 32'h0,
                      ob(32'h200, 1, 1, 0, 32'h104, 16'd4)));
      t.push_back(noex(32'h100, 0, ob(32'h200, 1, 0, 1, 32'h200, 16'd5)));
      // Correctly predicted branch: no flush, counter unchanged.
      t.push_back(exs(32'h100, 0, 1, 1, 32'h100, 1, 32'h200, 1, 32'h200,
                      ob(32'h200, 1, 0, 1, 32'h200, 16'd5)));
      foreach (t[i]) begin
         @(posedge clk); #1; drive(t[i]);
         @(negedge clk); e = exp_q.pop_front(); o = sample(); checks++;
         if (o !== e) $display("FAIL stall[%0d] got %h want %h", i, o, e); else passes++;
      end
   endtask

   task automatic test_alias();
      stim_t t[$]; obs_t e, o;
      t.push_back(exs(32'h100, 0, 1, 0, 32'h140, 0, 32'h0, 1, 32'h200,
                      ob(32'h144, 1, 1, 1, 32'h200, 16'd5)));
      // Killed follow-on instruction (ex_valid=0) must not flush.
      t.push_back(exs(32'h100, 0, 0, 0, 32'h140, 0, 32'h0, 1, 32'h200,
                      ob(32'h104, 1, 0, 0, 32'h104, 16'd6)));
      foreach (t[i]) begin
         @(posedge clk); #1; drive(t[i]);
         @(negedge clk); e = exp_q.pop_front(); o = sample(); checks++;
         if (o !== e) $display("FAIL alias[%0d] got %h want %h", i, o, e); else passes++;
      end
   endtask

   task automatic test_wrap();
      stim_t t[$]; obs_t e, o;
      t.push_back(noex(32'hFFFF_FFFC, 0, ob(32'h0, 1, 0, 0, 32'h0, 16'd6)));
      t.push_back(exs(32'hFFFF_FFFC, 0, 1, 1, 32'hFFFF_FFFC, 0, 32'h0, 1, 32'h8,
                      ob(32'h0, 1, 1, 0, 32'h0, 16'd6)));
      t.push_back(noex(32'hFFFF_FFFC, 0, ob(32'h0, 1, 0, 0, 32'h0, 16'd7)));
      foreach (t[i]) begin
         @(posedge clk); #1; drive(t[i]);
         @(negedge clk); e = exp_q.pop_front(); o = sample(); checks++;
         if (o !== e) $display("FAIL wrap[%0d] got %h want %h", i, o, e); else passes++;
      end
   endtask

   task automatic test_saturate();
      obs_t e, o;
      @(posedge clk); #1;
      drive(exs(32'h100, 0, 1, 0, 32'h80, 0, 32'h0, 1, 32'h0,
                ob(32'h84, 1, 1, 0, 32'h104, 16'hFFFF)));
      repeat (65540) @(posedge clk);
      @(negedge clk); e = exp_q.pop_front(); o = sample(); checks++;
      if (o !== e) $display("FAIL saturate got %h want %h", o, e); else passes++;
      @(posedge clk); #1;
      drive(noex(32'h100, 0, ob(32'h104, 1, 0, 0, 32'h104, 16'hFFFF)));
      @(negedge clk); e = exp_q.pop_front(); o = sample(); checks++;
      if (o !== e) $display("FAIL saturate_hold got %h want %h", o, e); else passes++;
   endtask

   task automatic test_reset_mid();
      stim_t t[$]; obs_t e, o;
      t.push_back(exs(32'h300, 0, 1, 1, 32'h100, 1, 32'h200, 0, 32'h0,
                      ob(32'h200, 1, 1, 0, 32'h304, 16'hFFFF)));
      t.push_back(noex(32'h100, 0, ob(32'h200, 1, 0, 1, 32'h200, 16'hFFFF)));
      foreach (t[i]) begin
         @(posedge clk); #1; drive(t[i]);
         @(negedge clk); e = exp_q.pop_front(); o = sample(); checks++;
         if (o !== e) $display("FAIL reset_mid_pre[%0d] got %h want %h", i, o, e); else passes++;
      end
      @(posedge clk); #1;
      drive(noex(32'h100, 0, ob(32'h104, 1, 0, 0, 32'h104, 16'd0)));
      rst = 1'b0;
      #2; e = exp_q.pop_front(); o = sample(); checks++;
      if (o !== e) $display("FAIL reset_mid got %h want %h", o, e); else passes++;
      @(negedge clk); rst = 1'b1;
      @(posedge clk); #1;
      drive(noex(32'h100, 0, ob(32'h104, 1, 0, 0, 32'h104, 16'd0)));
      @(negedge clk); e = exp_q.pop_front(); o = sample(); checks++;
      if (o !== e) $display("FAIL reset_mid_post got %h want %h", o, e); else passes++;
   endtask

   initial begin
      test_reset();
      test_alloc();
      test_train_down();
      test_stall();
      test_alias();
      test_wrap();
      test_saturate();
      test_reset_mid();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
